shunt_bus_arbiter: RTL and testbench
====================================

// Module: shunt_bus_arbiter
// PURPOSE
//  Shares one DW-bit output bus between the odd-side and even-side data
//  producers of the odd/even shunt. Uses round-robin arbitration with a
//  per-owner burst limit and a valid/ready handshake toward the consumer.
//  Replaces tri-state bus sharing with a registered-grant mux; the bus is
//  never released as 'z.
// PARAMETERS
//  DW         4   data width of each requester and of the shared bus
//  BURST_MAX  4   max consecutive transfers per owner while the other side is
//                 requesting; legal range 1..15
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous active-high reset
//  req_odd    in   1   odd producer has data; held until transferred
//  data_odd   in   DW  odd producer data; stable while req_odd is high
//  req_even   in   1   even producer has data; held until transferred
//  data_even  in   DW  even producer data; stable while req_even is high
//  bus_ready  in   1   consumer accepts bus_data this cycle
//  gnt_odd    out  1   odd side owns the bus (registered)
//  gnt_even   out  1   even side owns the bus (registered)
//  bus_valid  out  1   gnt_x & req_x of the current owner
//  bus_data   out  DW  data_x of the owner; 0 when no grant
//  owner      out  1   last or current owner: 0 = odd, 1 = even (registered)
// BEHAVIOUR
//  - Reset (async, any time): state IDLE, gnt_odd = gnt_even = 0,
//    bus_valid = 0, bus_data = 0, owner = 1 (odd wins the first tie),
//    burst_cnt = 0. Any in-flight burst is abandoned; no transfer completes.
//  - Transfer: bus_valid & bus_ready at a rising edge. Exactly one DW word
//    moves per transfer.
//  - The FSM has three states: IDLE, G_ODD, G_EVEN. Grants are one-hot or
//    zero, never both.
//  - IDLE: only req_odd -> G_ODD. Only req_even -> G_EVEN. Both -> the side
//    not equal to owner. Neither -> stay in IDLE.
//  - Latency: a req first seen high at edge N from IDLE gives gnt at edge N,
//    so bus_valid is high in cycle N+1. This is one cycle of arbitration
//    latency.
//  - G_X, each edge, in priority order:
//     1) req_X low: switch directly to G_other if req_other, else go to IDLE.
//        burst_cnt is cleared.
//     2) Transfer and burst_cnt == BURST_MAX-1 and req_other: switch directly
//        to G_other with no idle cycle. burst_cnt is cleared.
//     3) Transfer, other cases: burst_cnt += 1. If the other side is idle,
//        the count saturates at BURST_MAX-1 and ownership is kept.
//     4) No transfer (stall): hold state and burst_cnt.
//  - owner updates to X on every entry to G_X and holds through IDLE.
//  - burst_cnt width is 4 bits; it counts only transfers, never stall cycles.
//  - With both sides continuously requesting and bus_ready = 1, ownership
//    alternates every BURST_MAX transfers with 100% bus utilisation.
//  - A side that drops req on the same edge as its transfer completes is
//    released by rule 1 on the next edge. That cycle has bus_valid = 0, so no
//    duplicate transfer occurs.
//  - Dropping req before transfer violates protocol. The arbiter treats it as
//    release, and the word is lost.
//  - bus_data/bus_valid are combinational from the registered grant; there is
//    no path from bus_ready to the grants within the same cycle.
// TESTING
//  1 Reset mid-burst: G_EVEN with burst_cnt = 2, assert rst -> gnt = 0,
//    bus_valid = 0, owner = 1, bus_data = 0 immediately, without waiting for
//    clk.
//  2 Single requester: req_odd = 1 with data 9,8,7..., bus_ready = 1 ->
//    gnt_odd at the first edge, one word per cycle, never released (burst
//    saturates).
//  3 Contention, BURST_MAX = 4, both requesting, ready = 1 -> grant sequence
//    odd x4, even x4, odd x4, with no gap cycles.
//  4 Stall: owner odd, bus_ready = 0 for 5 cycles -> gnt_odd held, burst_cnt
//    unchanged, bus_data stable; even gets the bus only after 4 accepted
//    words.
//  5 Tie from IDLE after even was last owner: both reqs rise together ->
//    gnt_odd first; after odd releases, gnt_even next.
//  6 Release/switch: odd drops req after 2 words while even requesting ->
//    gnt_even on the next edge, burst_cnt = 0, even gets a full 4-word burst.

Source files
------------

// File: rtl/shunt_bus_arbiter.sv
// Round-robin arbiter sharing one DW-bit bus between the odd and even shunt producers.
// Registered one-hot grant drives a mux; each owner is limited to BURST_MAX words under contention.
module shunt_bus_arbiter #(
    parameter int unsigned DW        = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_odd,
    input  logic [DW-1:0] data_odd,
    input  logic          req_even,
    input  logic [DW-1:0] data_even,
    input  logic          bus_ready,
    output logic          gnt_odd,
    output logic          gnt_even,
    output logic          bus_valid,
    output logic [DW-1:0] bus_data,
    output logic          owner
);

    typedef enum logic [1:0] {StIdle, StGOdd, StGEven} state_e;

    localparam logic [3:0] CntLast = 4'(BURST_MAX - 1);

    state_e     state_q;
    logic [3:0] burst_cnt_q;
    logic       gnt_odd_q;
    logic       gnt_even_q;
    logic       owner_q;
    logic       xfer;

    assign gnt_odd   = gnt_odd_q;
    assign gnt_even  = gnt_even_q;
    assign owner     = owner_q;
    assign bus_valid = (gnt_odd_q & req_odd) | (gnt_even_q & req_even);
    assign xfer      = bus_valid & bus_ready;

    always_comb begin
        bus_data = '0;
        if (gnt_odd_q) begin
            bus_data = data_odd;
        end else if (gnt_even_q) begin
            bus_data = data_even;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_odd_q   <= 1'b0;
            gnt_even_q  <= 1'b0;
            owner_q     <= 1'b1;
            burst_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    // On a tie the side that did not own the bus last wins.
                    if (req_odd && (!req_even || owner_q)) begin
                        state_q     <= StGOdd;
                        gnt_odd_q   <= 1'b1;
                        gnt_even_q  <= 1'b0;
                        owner_q     <= 1'b0;
                        burst_cnt_q <= 4'd0;
                    end else if (req_even) begin
                        state_q     <= StGEven;
                        gnt_odd_q   <= 1'b0;
                        gnt_even_q  <= 1'b1;
                        owner_q     <= 1'b1;
                        burst_cnt_q <= 4'd0;
                    end
                end
                StGOdd: begin
                    if (!req_odd || (xfer && burst_cnt_q == CntLast && req_even)) begin
                        burst_cnt_q <= 4'd0;
                        if (req_even) begin
                            state_q    <= StGEven;
                            gnt_odd_q  <= 1'b0;
                            gnt_even_q <= 1'b1;
                            owner_q    <= 1'b1;
                        end else begin
                            state_q    <= StIdle;
                            gnt_odd_q  <= 1'b0;
                            gnt_even_q <= 1'b0;
                        end
                    end else if (xfer && burst_cnt_q != CntLast) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end
                end
                StGEven: begin
                    if (!req_even || (xfer && burst_cnt_q == CntLast && req_odd)) begin
                        burst_cnt_q <= 4'd0;
                        if (req_odd) begin
                            state_q    <= StGOdd;
                            gnt_odd_q  <= 1'b1;
                            gnt_even_q <= 1'b0;
                            owner_q    <= 1'b0;
                        end else begin
                            state_q    <= StIdle;
                            gnt_odd_q  <= 1'b0;
                            gnt_even_q <= 1'b0;
                        end
                    end else if (xfer && burst_cnt_q != CntLast) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    gnt_odd_q   <= 1'b0;
                    gnt_even_q  <= 1'b0;
                    burst_cnt_q <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shunt_bus_arbiter.sv
// Directed bench for shunt_bus_arbiter: inputs change on the falling edge, outputs checked 1 ns later.
// obs packs {gnt_odd, gnt_even, bus_valid, owner, bus_data}.
module tb_shunt_bus_arbiter;

    localparam int unsigned DW = 4;

    logic          clk;
    logic          rst;
    logic          req_odd;
    logic [DW-1:0] data_odd;
    logic          req_even;
    logic [DW-1:0] data_even;
    logic          bus_ready;
    logic          gnt_odd;
    logic          gnt_even;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic          owner;
    logic [7:0]    obs;

    int total = 0;
    int bad   = 0;

    shunt_bus_arbiter #(.DW(DW), .BURST_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_odd   (req_odd),
        .data_odd  (data_odd),
        .req_even  (req_even),
        .data_even (data_even),
        .bus_ready (bus_ready),
        .gnt_odd   (gnt_odd),
        .gnt_even  (gnt_even),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .owner     (owner)
    );

    assign obs = {gnt_odd, gnt_even, bus_valid, owner, bus_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b1;
        req_odd   = 1'b0;
        req_even  = 1'b0;
        data_odd  = '0;
        data_even = '0;
        bus_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        do_reset();
        rst = 1'b1;
        #1;
        exp = 8'b0001_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_state: got %b want %b", obs, exp); end
        total++;
        if (dut.burst_cnt_q !== 4'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d want 0", dut.burst_cnt_q);
        end
        @(negedge clk);
        rst      = 1'b0;
        req_odd  = 1'b1;
        data_odd = 4'hA;
        @(negedge clk);
        #1;
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'hA};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_pre_odd: got %b want %b", obs, exp); end
        #2;
        rst = 1'b1;
        #1;
        exp = 8'b0001_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_async_odd: got %b want %b", obs, exp); end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] exp;
        do_reset();
        req_even  = 1'b1;
        data_even = 4'd6;
        bus_ready = 1'b1;
        #1;
        exp = 8'b0001_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midrst_latency: got %b want %b", obs, exp); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'd6};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL midrst_word%0d: got %b want %b", i, obs, exp);
            end
        end
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        total++;
        if (dut.burst_cnt_q !== 4'd2) begin
            bad++; $display("FAIL midrst_cnt: got %0d want 2", dut.burst_cnt_q);
        end
        #2;
        rst = 1'b1;
        #1;
        exp = 8'b0001_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midrst_async: got %b want %b", obs, exp); end
        total++;
        if (dut.burst_cnt_q !== 4'd0) begin
            bad++; $display("FAIL midrst_cnt_clr: got %0d want 0", dut.burst_cnt_q);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        do_reset();
        req_odd   = 1'b1;
        data_odd  = 4'd9;
        bus_ready = 1'b1;
        #1;
        exp = 8'b0001_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_latency: got %b want %b", obs, exp); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            data_odd = 4'(9 - i);
            #1;
            exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'(9 - i)};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL single_word%0d: got %b want %b", i, obs, exp);
            end
        end
        total++;
        if (dut.burst_cnt_q !== 4'd3) begin
            bad++; $display("FAIL single_sat: got %0d want 3", dut.burst_cnt_q);
        end
        @(negedge clk);
        req_odd = 1'b0;
        #1;
        exp = 8'b1000_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_drop: got %b want %b", obs, exp); end
        @(negedge clk);
        #1;
        exp = 8'b0000_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_idle: got %b want %b", obs, exp); end
    endtask

    task automatic test_contention();
        logic [7:0] exp;
        do_reset();
        req_odd   = 1'b1;
        req_even  = 1'b1;
        data_odd  = 4'd5;
        data_even = 4'hC;
        bus_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (i < 4 || i >= 8) exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd5};
            else                 exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'hC};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL contend_cyc%0d: got %b want %b", i, obs, exp);
            end
        end
        @(negedge clk);
        req_odd  = 1'b0;
        req_even = 1'b0;
        @(negedge clk);
        #1;
        exp = 8'b0001_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL contend_idle: got %b want %b", obs, exp); end
    endtask

    task automatic test_stall();
        logic [7:0] exp;
        do_reset();
        req_odd   = 1'b1;
        data_odd  = 4'd3;
        bus_ready = 1'b1;
        @(negedge clk);
        #1;
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_first: got %b want %b", obs, exp); end
        @(negedge clk);
        data_odd  = 4'd4;
        bus_ready = 1'b0;
        req_even  = 1'b1;
        data_even = 4'hE;
        for (int s = 0; s < 5; s++) begin
            #1;
            exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd4};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL stall_hold%0d: got %b want %b", s, obs, exp);
            end
            total++;
            if (dut.burst_cnt_q !== 4'd1) begin
                bad++; $display("FAIL stall_cnt%0d: got %0d want 1", s, dut.burst_cnt_q);
            end
            @(negedge clk);
        end
        bus_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            data_odd = 4'(4 + w);
            #1;
            exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'(4 + w)};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL stall_resume%0d: got %b want %b", w, obs, exp);
            end
            @(negedge clk);
        end
        #1;
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'hE};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_switch: got %b want %b", obs, exp); end
    endtask

    task automatic test_tie();
        logic [7:0] exp;
        do_reset();
        req_even  = 1'b1;
        data_even = 4'd7;
        bus_ready = 1'b1;
        @(negedge clk);
        #1;
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'd7};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL tie_even_word: got %b want %b", obs, exp); end
        @(negedge clk);
        req_even = 1'b0;
        @(negedge clk);
        #1;
        exp = 8'b0001_0000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL tie_idle: got %b want %b", obs, exp); end
        req_odd   = 1'b1;
        req_even  = 1'b1;
        data_odd  = 4'd1;
        data_even = 4'd2;
        @(negedge clk);
        #1;
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL tie_odd_first: got %b want %b", obs, exp); end
        @(negedge clk);
        req_odd = 1'b0;
        #1;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL tie_odd_drop: got %b want %b", obs, exp); end
        @(negedge clk);
        #1;
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'd2};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL tie_even_next: got %b want %b", obs, exp); end
    endtask

    task automatic test_release();
        logic [7:0] exp;
        do_reset();
        req_odd   = 1'b1;
        req_even  = 1'b1;
        data_odd  = 4'd1;
        data_even = 4'd8;
        bus_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL release_odd%0d: got %b want %b", i, obs, exp);
            end
        end
        @(negedge clk);
        req_odd = 1'b0;
        #1;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL release_drop: got %b want %b", obs, exp); end
        @(negedge clk);
        req_odd = 1'b1;
        #1;
        total++;
        if (dut.burst_cnt_q !== 4'd0) begin
            bad++; $display("FAIL release_cnt: got %0d want 0", dut.burst_cnt_q);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) #1;
            exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'd8};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL release_even%0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        #1;
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL release_back: got %b want %b", obs, exp); end
    endtask

    initial begin
        rst       = 1'b1;
        req_odd   = 1'b0;
        req_even  = 1'b0;
        data_odd  = '0;
        data_even = '0;
        bus_ready = 1'b0;
        test_reset();
        test_reset_mid_burst();
        test_single();
        test_contention();
        test_stall();
        test_tie();
        test_release();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
